// File: rtl/fft32_pkg.sv
// Shared definitions for the 32-point FFT output side: frame geometry,
// lane/bin index reversal and the read-side FSM state type.
package fft32_pkg;

  localparam int N_PTS = 32;
  localparam int LOG2N = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  // Reverse the low 'width' bits of idx; bits above 'width' come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < width) r[width-1-b] = idx[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft32_out_serializer_frame_bank.sv
// One frame of complex samples: whole-frame parallel write, single-lane read.
module fft_frame_bank
  import fft32_pkg::*;
#(
  parameter int N  = N_PTS,
  parameter int W  = 32,
  localparam int LW = $clog2(N)
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [N*W-1:0] wr_r_i,
  input  logic [N*W-1:0] wr_i_i,
  input  logic [LW-1:0]  rd_lane_i,
  output logic [W-1:0]   rd_r_o,
  output logic [W-1:0]   rd_i_o
);

  logic [W-1:0] mem_r_q [N];
  logic [W-1:0] mem_i_q [N];

  // Capture every lane of the incoming frame on a write strobe; payload only, never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < N; k++) begin
        mem_r_q[k] <= wr_r_i[k*W +: W];
        mem_i_q[k] <= wr_i_i[k*W +: W];
      end
    end
  end

  assign rd_r_o = mem_r_q[rd_lane_i];
  assign rd_i_o = mem_i_q[rd_lane_i];

endmodule

// File: rtl/fft32_out_serializer.sv
// Ping-pong frame buffer that turns one parallel FFT result frame into a
// natural-order stream of complex bins under valid/ready flow control.
module fft32_out_serializer
  import fft32_pkg::*;
#(
  parameter int N       = N_PTS,
  parameter int W       = 32,
  parameter bit BIT_REV = 1'b1,
  localparam int LW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_valid,
  output logic           frame_ready,
  input  logic [N*W-1:0] frame_r,
  input  logic [N*W-1:0] frame_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_r,
  output logic [W-1:0]   out_i,
  output logic [LW-1:0]  out_index,
  output logic           out_last,
  output logic [1:0]     frames_pending
);

  logic [1:0]    full_q, full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [LW-1:0] cnt_q, cnt_d;
  rd_state_e     state_q, state_d;

  logic          capture;
  logic          xfer;
  logic          last_bin;
  logic [LW-1:0] rd_lane;
  logic [W-1:0]  b0_r, b0_i, b1_r, b1_i;

  assign frame_ready = rst && !full_q[wr_sel_q];
  assign capture     = frame_valid && frame_ready;
  assign out_valid   = (state_q == STREAM);
  assign xfer        = out_valid && out_ready;
  assign last_bin    = (cnt_q == LW'(N - 1));

  // The butterfly network leaves bin j in lane bitrev(j) when BIT_REV is set.
  assign rd_lane = BIT_REV ? LW'(bit_reverse(32'(cnt_q), LW)) : cnt_q;

  fft_frame_bank #(.N(N), .W(W)) u_bank0 (
    .clk       (clk),
    .we_i      (capture && !wr_sel_q),
    .wr_r_i    (frame_r),
    .wr_i_i    (frame_i),
    .rd_lane_i (rd_lane),
    .rd_r_o    (b0_r),
    .rd_i_o    (b0_i)
  );

  fft_frame_bank #(.N(N), .W(W)) u_bank1 (
    .clk       (clk),
    .we_i      (capture && wr_sel_q),
    .wr_r_i    (frame_r),
    .wr_i_i    (frame_i),
    .rd_lane_i (rd_lane),
    .rd_r_o    (b1_r),
    .rd_i_o    (b1_i)
  );

  // Outputs come only from registered state, so out_ready never reaches out_valid.
  assign out_index      = cnt_q;
  assign out_last       = out_valid && last_bin;
  assign out_r          = out_valid ? (rd_sel_q ? b1_r : b0_r) : '0;
  assign out_i          = out_valid ? (rd_sel_q ? b1_i : b0_i) : '0;
  assign frames_pending = 2'(full_q[0]) + 2'(full_q[1]);

  // Next-state: capture fills bank wr_sel, the final transfer releases bank rd_sel.
  // A capture needs an empty bank and a release needs a full one, so both never hit the same bank.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    cnt_d    = cnt_q;
    state_d  = state_q;

    if (capture) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_sel_q]) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (!last_bin) begin
            cnt_d = cnt_q + LW'(1);
          end else begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            cnt_d            = '0;
            // Chain straight into the other bank only if it was already full.
            state_d          = full_q[~rd_sel_q] ? STREAM : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset discards any pending or partly streamed frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_fft32_out_serializer.sv
// Scoreboard bench: accepted frames are expanded into expected bins by a
// plain-arithmetic model; monitors pop and compare on every output transfer.
module tb_fft32_out_serializer;

  localparam int N = 32;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_valid, frame_ready;
  logic [N*W-1:0] frame_r, frame_i;
  logic           out_valid, out_ready, out_last;
  logic [W-1:0]   out_r, out_i;
  logic [4:0]     out_index;
  logic [1:0]     frames_pending;

  logic           nr_frame_valid, nr_frame_ready;
  logic [N*W-1:0] nr_frame_r, nr_frame_i;
  logic           nr_out_valid, nr_out_ready, nr_out_last;
  logic [W-1:0]   nr_out_r, nr_out_i;
  logic [4:0]     nr_out_index;
  logic [1:0]     nr_frames_pending;

  always #5 clk = ~clk;

  fft32_out_serializer #(.N(N), .W(W), .BIT_REV(1'b1)) dut (
    .clk(clk), .rst(rst),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_r(frame_r), .frame_i(frame_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_index(out_index),
    .out_last(out_last), .frames_pending(frames_pending)
  );

  fft32_out_serializer #(.N(N), .W(W), .BIT_REV(1'b0)) dut_nr (
    .clk(clk), .rst(rst),
    .frame_valid(nr_frame_valid), .frame_ready(nr_frame_ready),
    .frame_r(nr_frame_r), .frame_i(nr_frame_i),
    .out_valid(nr_out_valid), .out_ready(nr_out_ready),
    .out_r(nr_out_r), .out_i(nr_out_i), .out_index(nr_out_index),
    .out_last(nr_out_last), .frames_pending(nr_frames_pending)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] r;
    logic [W-1:0] i;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   pcnt = 0;
  int   last_cyc = -1;
  int   first_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rev5(input int j);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((j & (1 << b)) != 0) r = r | (1 << (4 - b));
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_bus();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = $urandom();
    return v;
  endfunction

  // Reference: natural-order bin j lives in lane bitrev(j) (or lane j when not reversed).
  task automatic model(input bit rev, input logic [N*W-1:0] fr, input logic [N*W-1:0] fi);
    exp_t e;
    int lane;
    for (int j = 0; j < N; j++) begin
      lane  = rev ? rev5(j) : j;
      e.idx = j;
      e.r   = fr[lane*W +: W];
      e.i   = fi[lane*W +: W];
      if (rev) q1.push_back(e);
      else     q0.push_back(e);
    end
  endtask

  // out_ready pattern generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       begin out_ready = (pcnt % 3 == 0); pcnt++; end
      2:       out_ready = 1'b0;
      3:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor for the bit-reversed instance: ordering, data, last flag, hold stability.
  logic         hold_v = 1'b0;
  logic [W-1:0] h_r, h_i;
  logic [4:0]   h_idx;
  logic         h_last;
  exp_t         m1;
  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_r", 64'(out_r), 64'(h_r));
        chk("hold_i", 64'(out_i), 64'(h_i));
        chk("hold_idx_last", 64'({out_index, out_last}), 64'({h_idx, h_last}));
      end
      hold_v = 1'b0;
      if (out_valid && !out_ready) begin
        hold_v = 1'b1;
        h_r = out_r; h_i = out_i; h_idx = out_index; h_last = out_last;
      end else if (out_valid && out_ready) begin
        if (q1.size() == 0) begin
          chk("unexpected_bin_index", 64'(out_index), 64'hFFFF);
        end else begin
          m1 = q1.pop_front();
          chk("bin_index", 64'(out_index), 64'(m1.idx));
          chk("bin_r", 64'(out_r), 64'(m1.r));
          chk("bin_i", 64'(out_i), 64'(m1.i));
          chk("bin_last", 64'(out_last), 64'(m1.idx == N - 1));
        end
        if (out_index == 5'd0) first_cyc = cyc;
        if (out_last) last_cyc = cyc;
      end
    end
  end

  // Monitor for the natural-order instance.
  exp_t m0;
  always @(negedge clk) begin
    if (rst && nr_out_valid && nr_out_ready) begin
      if (q0.size() == 0) begin
        chk("nr_unexpected_bin_index", 64'(nr_out_index), 64'hFFFF);
      end else begin
        m0 = q0.pop_front();
        chk("nr_bin_index", 64'(nr_out_index), 64'(m0.idx));
        chk("nr_bin_r", 64'(nr_out_r), 64'(m0.r));
        chk("nr_bin_i", 64'(nr_out_i), 64'(m0.i));
        chk("nr_bin_last", 64'(nr_out_last), 64'(m0.idx == N - 1));
      end
    end
  end

  // Offer one frame (called just after a rising edge); acc = cycle in which the accept was seen.
  task automatic send(input bit which, input logic [N*W-1:0] fr, input logic [N*W-1:0] fi,
                      output int acc);
    acc = -1;
    if (which) begin frame_valid = 1'b1; frame_r = fr; frame_i = fi; end
    else begin nr_frame_valid = 1'b1; nr_frame_r = fr; nr_frame_i = fi; end
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (which ? frame_ready : nr_frame_ready) begin
        acc = cyc;
        model(which, fr, fi);
        @(posedge clk); #1;
        if (which) frame_valid = 1'b0; else nr_frame_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 64'(0), 64'(1));
    if (which) frame_valid = 1'b0; else nr_frame_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit which);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (which ? (q1.size() == 0 && !out_valid) : (q0.size() == 0 && !nr_out_valid)) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("drain_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_idx(input int target);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (out_valid && out_index == 5'(target)) return;
    end
    chk("wait_idx_timeout", 64'(0), 64'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] fr, fi;
    int acc1, acc2, acc3, l1, nacc;

    rst = 1'b0;
    frame_valid = 1'b0; frame_r = '0; frame_i = '0;
    nr_frame_valid = 1'b0; nr_frame_r = '0; nr_frame_i = '0;
    nr_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_frame_ready", 64'(frame_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_index", 64'(out_index), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_pending", 64'(frames_pending), 64'(0));
    chk("rst_out_r", 64'(out_r), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_frame_ready", 64'(frame_ready), 64'(1));
    @(posedge clk); #1;

    // Single bit-reversed frame, lane k: r=k, i=100+k
    for (int k = 0; k < N; k++) begin fr[k*W +: W] = W'(k); fi[k*W +: W] = W'(100 + k); end
    send(1'b1, fr, fi, acc1);
    @(negedge clk);
    chk("latency_c1_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("latency_c2_valid", 64'(out_valid), 64'(1));
    chk("latency_c2_index", 64'(out_index), 64'(0));
    wait_idx(1);  chk("idx1_r", 64'(out_r), 64'(16));
    wait_idx(3);  chk("idx3_r", 64'(out_r), 64'(24));
    wait_idx(31); chk("idx31_r", 64'(out_r), 64'(31));
    chk("idx31_last", 64'(out_last), 64'(1));
    @(posedge clk); #1;
    drain(1'b1);
    chk("single_pending_after", 64'(frames_pending), 64'(0));
    chk("single_valid_after", 64'(out_valid), 64'(0));

    // Backpressure 1,0,0,1,0,0...
    pcnt = 0; rdy_mode = 1;
    send(1'b1, rand_bus(), rand_bus(), acc1);
    drain(1'b1);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Three frames back-to-back
    send(1'b1, rand_bus(), rand_bus(), acc1);
    send(1'b1, rand_bus(), rand_bus(), acc2);
    chk("b2b_consecutive_accept", 64'(acc2 - acc1), 64'(1));
    @(negedge clk);
    chk("b2b_frame_ready_low", 64'(frame_ready), 64'(0));
    chk("b2b_pending_two", 64'(frames_pending), 64'(2));
    @(posedge clk); #1;
    send(1'b1, rand_bus(), rand_bus(), acc3);
    l1 = last_cyc;
    chk("f3_accept_after_f1_last", 64'(acc3), 64'(l1 + 1));
    chk("f2_bin0_no_gap", 64'(first_cyc), 64'(l1 + 1));
    drain(1'b1);

    // Reset mid-stream at index 10 with one frame pending
    send(1'b1, rand_bus(), rand_bus(), acc1);
    send(1'b1, rand_bus(), rand_bus(), acc2);
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (out_valid && out_index == 5'd10) break;
    end
    chk("mid_reset_reached_idx10", 64'(out_index), 64'(10));
    rst = 1'b0;
    q1.delete();
    @(posedge clk); #1;
    chk("mid_reset_valid", 64'(out_valid), 64'(0));
    chk("mid_reset_index", 64'(out_index), 64'(0));
    chk("mid_reset_pending", 64'(frames_pending), 64'(0));
    chk("mid_reset_ready_low", 64'(frame_ready), 64'(0));
    chk("mid_reset_out_i", 64'(out_i), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_ready_high", 64'(frame_ready), 64'(1));
    @(posedge clk); #1;
    send(1'b1, rand_bus(), rand_bus(), acc1);
    drain(1'b1);

    // Natural-order instance: lane k r=k, then random
    for (int k = 0; k < N; k++) begin fr[k*W +: W] = W'(k); fi[k*W +: W] = $urandom(); end
    send(1'b0, fr, fi, acc1);
    send(1'b0, rand_bus(), rand_bus(), acc2);
    drain(1'b0);

    // frame_valid held high, downstream stalled
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nacc = 0;
    for (int t = 0; t < 100; t++) begin
      fr = rand_bus(); fi = rand_bus();
      frame_valid = 1'b1; frame_r = fr; frame_i = fi;
      @(negedge clk);
      if (frame_ready) begin nacc++; model(1'b1, fr, fi); end
      @(posedge clk); #1;
    end
    chk("stall_accept_count", 64'(nacc), 64'(2));
    chk("stall_frame_ready", 64'(frame_ready), 64'(0));
    chk("stall_out_index", 64'(out_index), 64'(0));
    chk("stall_out_valid", 64'(out_valid), 64'(1));
    chk("stall_pending", 64'(frames_pending), 64'(2));
    frame_valid = 1'b0;
    rdy_mode = 0;
    drain(1'b1);

    // Random backpressure, random frame gaps
    rdy_mode = 3;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(1'b1, rand_bus(), rand_bus(), acc1);
    end
    drain(1'b1);
    chk("final_q1_empty", 64'(q1.size()), 64'(0));
    chk("final_q0_empty", 64'(q0.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
